// File: rtl/axi4_stream_scoreboard.sv
// axi4_stream_scoreboard
//   Passive in-order scoreboard for CN AXI4-Stream channels. Expected beats
//   (source-side taps) are buffered per channel and compared against observed
//   beats (sink-side taps) in arrival order. Comparison, packet and error
//   counts are accumulated in saturating counters.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   clr                   synchronous clear of FIFOs, counters and sticky flags
//   exp_t*                expected-side taps (valid/ready/last per channel,
//                         data and keep packed by channel)
//   obs_t*                observed-side taps, same layout as exp_t*
//   cmp_cnt               beats compared (saturating)
//   pkt_cnt               compared beats carrying obs tlast (saturating)
//   err_cnt               total errors (saturating)
//   err                   per-channel one-cycle error pulse
//   ovf                   sticky: expected beat dropped, FIFO full
//   unexp                 sticky: observed beat with nothing to compare
//   idle                  all FIFOs empty (registered)

module axi4_stream_scoreboard #(
    parameter int DN    = 1,
    parameter int CN    = 2,
    parameter int DEPTH = 16,
    parameter int LW    = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 clr,
    input  logic [CN-1:0]        exp_tvalid,
    input  logic [CN-1:0]        exp_tready,
    input  logic [CN-1:0]        exp_tlast,
    input  logic [CN*8*DN-1:0]   exp_tdata,
    input  logic [CN*DN-1:0]     exp_tkeep,
    input  logic [CN-1:0]        obs_tvalid,
    input  logic [CN-1:0]        obs_tready,
    input  logic [CN-1:0]        obs_tlast,
    input  logic [CN*8*DN-1:0]   obs_tdata,
    input  logic [CN*DN-1:0]     obs_tkeep,
    output logic [LW-1:0]        cmp_cnt,
    output logic [LW-1:0]        pkt_cnt,
    output logic [LW-1:0]        err_cnt,
    output logic [CN-1:0]        err,
    output logic [CN-1:0]        ovf,
    output logic [CN-1:0]        unexp,
    output logic                 idle
);

    localparam int DW = 8 * DN;
    localparam int BW = DW + DN + 1;          // {data, keep, last}
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(2 * CN + 1);   // holds up to 2 events per channel

    typedef logic [AW:0] ptr_t;

    logic [BW-1:0] mem [CN][DEPTH];
    ptr_t          wr_ptr    [CN];
    ptr_t          rd_ptr    [CN];
    ptr_t          wr_ptr_nx [CN];
    ptr_t          rd_ptr_nx [CN];
    logic [BW-1:0] exp_beat  [CN];
    logic [BW-1:0] obs_beat  [CN];
    logic [BW-1:0] ref_beat  [CN];

    logic [CN-1:0] exp_xfer;
    logic [CN-1:0] obs_xfer;
    logic [CN-1:0] fifo_empty;
    logic [CN-1:0] fifo_full;
    logic [CN-1:0] bypass;
    logic [CN-1:0] do_pop;
    logic [CN-1:0] do_push;
    logic [CN-1:0] ovf_ev;
    logic [CN-1:0] unexp_ev;
    logic [CN-1:0] cmp_ev;
    logic [CN-1:0] pkt_ev;
    logic [CN-1:0] mis_ev;
    logic [CN-1:0] err_ev;
    logic [CN-1:0] empty_nx;

    logic [SW-1:0] cmp_sum;
    logic [SW-1:0] pkt_sum;
    logic [SW-1:0] err_sum;

    // keep and last must match exactly; data only on bytes the reference keeps
    function automatic logic beat_mismatch(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic m;
        m = (a[DN:1] != b[DN:1]) || (a[0] != b[0]);
        for (int i = 0; i < DN; i++) begin
            if (a[1+i] && (a[DN+1+8*i +: 8] != b[DN+1+8*i +: 8]))
                m = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [LW-1:0] sat_add(input logic [LW-1:0] a, input logic [SW-1:0] b);
        logic [LW:0] s;
        s = {1'b0, a} + (LW+1)'(b);
        return s[LW] ? {LW{1'b1}} : s[LW-1:0];
    endfunction

    for (genvar g = 0; g < CN; g++) begin : g_chan
        assign exp_xfer[g]   = exp_tvalid[g] & exp_tready[g];
        assign obs_xfer[g]   = obs_tvalid[g] & obs_tready[g];
        assign exp_beat[g]   = {exp_tdata[g*DW +: DW], exp_tkeep[g*DN +: DN], exp_tlast[g]};
        assign obs_beat[g]   = {obs_tdata[g*DW +: DW], obs_tkeep[g*DN +: DN], obs_tlast[g]};

        assign fifo_empty[g] = (wr_ptr[g] == rd_ptr[g]);
        assign fifo_full[g]  = (wr_ptr[g][AW] != rd_ptr[g][AW]) &&
                               (wr_ptr[g][AW-1:0] == rd_ptr[g][AW-1:0]);

        // An obs beat on an empty FIFO consumes a same-cycle exp beat directly.
        assign bypass[g]     = obs_xfer[g] & fifo_empty[g] & exp_xfer[g];
        assign do_pop[g]     = obs_xfer[g] & ~fifo_empty[g];
        assign unexp_ev[g]   = obs_xfer[g] & fifo_empty[g] & ~exp_xfer[g];
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        assign ovf_ev[g]     = exp_xfer[g] & fifo_full[g] & ~do_pop[g];
        assign do_push[g]    = exp_xfer[g] & ~bypass[g] & ~ovf_ev[g];

        assign ref_beat[g]   = bypass[g] ? exp_beat[g] : mem[g][rd_ptr[g][AW-1:0]];
        assign cmp_ev[g]     = do_pop[g] | bypass[g];
        assign pkt_ev[g]     = cmp_ev[g] & obs_tlast[g];
        assign mis_ev[g]     = cmp_ev[g] & beat_mismatch(ref_beat[g], obs_beat[g]);
        assign err_ev[g]     = mis_ev[g] | ovf_ev[g] | unexp_ev[g];

        assign wr_ptr_nx[g]  = wr_ptr[g] + {{AW{1'b0}}, do_push[g]};
        assign rd_ptr_nx[g]  = rd_ptr[g] + {{AW{1'b0}}, do_pop[g]};
        assign empty_nx[g]   = (wr_ptr_nx[g] == rd_ptr_nx[g]);
    end

    always_comb begin
        cmp_sum = '0;
        pkt_sum = '0;
        err_sum = '0;
        for (int c = 0; c < CN; c++) begin
            cmp_sum = cmp_sum + SW'(cmp_ev[c]);
            pkt_sum = pkt_sum + SW'(pkt_ev[c]);
            err_sum = err_sum + SW'(mis_ev[c]) + SW'(ovf_ev[c]) + SW'(unexp_ev[c]);
        end
    end

    always_ff @(posedge aclk) begin
        if (!clr) begin
            for (int c = 0; c < CN; c++) begin
                if (do_push[c])
                    mem[c][wr_ptr[c][AW-1:0]] <= exp_beat[c];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < CN; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            cmp_cnt <= '0;
            pkt_cnt <= '0;
            err_cnt <= '0;
            err     <= '0;
            ovf     <= '0;
            unexp   <= '0;
            idle    <= 1'b1;
        end else if (clr) begin
            for (int c = 0; c < CN; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            cmp_cnt <= '0;
            pkt_cnt <= '0;
            err_cnt <= '0;
            err     <= '0;
            ovf     <= '0;
            unexp   <= '0;
            idle    <= 1'b1;
        end else begin
            for (int c = 0; c < CN; c++) begin
                wr_ptr[c] <= wr_ptr_nx[c];
                rd_ptr[c] <= rd_ptr_nx[c];
            end
            cmp_cnt <= sat_add(cmp_cnt, cmp_sum);
            pkt_cnt <= sat_add(pkt_cnt, pkt_sum);
            err_cnt <= sat_add(err_cnt, err_sum);
            err     <= err_ev;
            ovf     <= ovf | ovf_ev;
            unexp   <= unexp | unexp_ev;
            idle    <= &empty_nx;
        end
    end

endmodule

// File: tb/tb_axi4_stream_scoreboard.sv
// Bench for axi4_stream_scoreboard (DN=4, CN=2, DEPTH=4, LW=3).
// A queue-based reference model predicts the outputs after each clock edge;
// predictions are queued and compared on the following falling edge.
// Scenario tasks additionally check end-of-scenario values inline.

module tb_axi4_stream_scoreboard;

    localparam int DN    = 4;
    localparam int CN    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int MAXC  = 7;

    typedef logic [36:0] beat_t;   // {data[31:0], keep[3:0], last}

    typedef struct packed {
        logic [1:0] e;
        logic [2:0] c;
        logic [2:0] p;
        logic [2:0] x;
        logic [1:0] o;
        logic [1:0] u;
        logic       i;
    } pred_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          clr;
    logic [1:0]    exp_tvalid, exp_tready, exp_tlast;
    logic [63:0]   exp_tdata;
    logic [7:0]    exp_tkeep;
    logic [1:0]    obs_tvalid, obs_tready, obs_tlast;
    logic [63:0]   obs_tdata;
    logic [7:0]    obs_tkeep;
    logic [2:0]    cmp_cnt, pkt_cnt, err_cnt;
    logic [1:0]    err, ovf, unexp;
    logic          idle;

    int            errors = 0;
    int            checks = 0;

    beat_t         mq [2][$];
    pred_t         pred_q [$];
    int            m_cmp, m_pkt, m_err;
    logic [1:0]    m_ovf, m_unexp;

    axi4_stream_scoreboard #(.DN(DN), .CN(CN), .DEPTH(DEPTH), .LW(LW)) dut (
        .aclk(aclk), .areset(areset), .clr(clr),
        .exp_tvalid(exp_tvalid), .exp_tready(exp_tready), .exp_tlast(exp_tlast),
        .exp_tdata(exp_tdata), .exp_tkeep(exp_tkeep),
        .obs_tvalid(obs_tvalid), .obs_tready(obs_tready), .obs_tlast(obs_tlast),
        .obs_tdata(obs_tdata), .obs_tkeep(obs_tkeep),
        .cmp_cnt(cmp_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
        .err(err), .ovf(ovf), .unexp(unexp), .idle(idle)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic differ(input beat_t r, input beat_t o);
        logic m;
        m = (r[4:1] != o[4:1]) || (r[0] != o[0]);
        for (int b = 0; b < 4; b++)
            if (r[1+b] && (r[5+8*b +: 8] != o[5+8*b +: 8])) m = 1'b1;
        return m;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_flush();
        mq[0].delete();
        mq[1].delete();
        m_cmp = 0; m_pkt = 0; m_err = 0;
        m_ovf = '0; m_unexp = '0;
    endtask

    task automatic set_exp(input int c, input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_tvalid[c] = 1'b1; exp_tready[c] = 1'b1;
        exp_tdata[c*32 +: 32] = d; exp_tkeep[c*4 +: 4] = k; exp_tlast[c] = l;
    endtask

    task automatic set_obs(input int c, input logic [31:0] d, input logic [3:0] k, input logic l);
        obs_tvalid[c] = 1'b1; obs_tready[c] = 1'b1;
        obs_tdata[c*32 +: 32] = d; obs_tkeep[c*4 +: 4] = k; obs_tlast[c] = l;
    endtask

    // Model the current input cycle, clock it, queue the prediction, then
    // scramble the idle inputs so non-handshake values are never meaningful.
    task automatic step();
        logic [1:0] e_pulse;
        int dc, dp, de;
        pred_t p;
        e_pulse = '0; dc = 0; dp = 0; de = 0;
        if (clr) begin
            model_flush();
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic pe, po, byp, has_ref;
                beat_t eb, ob, rb;
                pe = exp_tvalid[c] & exp_tready[c];
                po = obs_tvalid[c] & obs_tready[c];
                eb = {exp_tdata[c*32 +: 32], exp_tkeep[c*4 +: 4], exp_tlast[c]};
                ob = {obs_tdata[c*32 +: 32], obs_tkeep[c*4 +: 4], obs_tlast[c]};
                rb = '0; byp = 1'b0; has_ref = 1'b0;
                if (po) begin
                    if (mq[c].size() > 0) begin
                        rb = mq[c].pop_front(); has_ref = 1'b1;
                    end else if (pe) begin
                        rb = eb; has_ref = 1'b1; byp = 1'b1;
                    end else begin
                        de++; e_pulse[c] = 1'b1; m_unexp[c] = 1'b1;
                    end
                end
                if (pe && !byp) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(eb);
                    else begin
                        de++; e_pulse[c] = 1'b1; m_ovf[c] = 1'b1;
                    end
                end
                if (has_ref) begin
                    dc++;
                    if (ob[0]) dp++;
                    if (differ(rb, ob)) begin
                        de++; e_pulse[c] = 1'b1;
                    end
                end
            end
            m_cmp = sat(m_cmp + dc);
            m_pkt = sat(m_pkt + dp);
            m_err = sat(m_err + de);
        end
        @(posedge aclk);
        p.e = e_pulse; p.c = 3'(m_cmp); p.p = 3'(m_pkt); p.x = 3'(m_err);
        p.o = m_ovf; p.u = m_unexp;
        p.i = (mq[0].size() == 0) && (mq[1].size() == 0);
        pred_q.push_back(p);
        #1;
        exp_tvalid = '0; obs_tvalid = '0;
        exp_tready = 2'($urandom); obs_tready = 2'($urandom);
        exp_tdata = {$urandom, $urandom}; obs_tdata = {$urandom, $urandom};
        exp_tkeep = 8'($urandom); obs_tkeep = 8'($urandom);
        exp_tlast = 2'($urandom); obs_tlast = 2'($urandom);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    always @(negedge aclk) begin : monitor
        pred_t p;
        if (pred_q.size() > 0) begin
            p = pred_q.pop_front();
            checks++; if (err !== p.e) begin errors++; $display("FAIL sb_err: got %b want %b at %0t", err, p.e, $time); end
            checks++; if (cmp_cnt !== p.c) begin errors++; $display("FAIL sb_cmp_cnt: got %0d want %0d at %0t", cmp_cnt, p.c, $time); end
            checks++; if (pkt_cnt !== p.p) begin errors++; $display("FAIL sb_pkt_cnt: got %0d want %0d at %0t", pkt_cnt, p.p, $time); end
            checks++; if (err_cnt !== p.x) begin errors++; $display("FAIL sb_err_cnt: got %0d want %0d at %0t", err_cnt, p.x, $time); end
            checks++; if (ovf !== p.o) begin errors++; $display("FAIL sb_ovf: got %b want %b at %0t", ovf, p.o, $time); end
            checks++; if (unexp !== p.u) begin errors++; $display("FAIL sb_unexp: got %b want %b at %0t", unexp, p.u, $time); end
            checks++; if (idle !== p.i) begin errors++; $display("FAIL sb_idle: got %b want %b at %0t", idle, p.i, $time); end
        end
    end

    task automatic test_reset();
        checks++; if (cmp_cnt !== 3'd0) begin errors++; $display("FAIL reset_cmp: got %0d want 0", cmp_cnt); end
        checks++; if (pkt_cnt !== 3'd0) begin errors++; $display("FAIL reset_pkt: got %0d want 0", pkt_cnt); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", ovf); end
        checks++; if (unexp !== 2'b00) begin errors++; $display("FAIL reset_unexp: got %b want 00", unexp); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    endtask

    task automatic test_in_order();
        do_clr();
        for (int t = 0; t < 8; t++) begin
            if (t < 5) set_exp(0, 32'h0000_00A5, 4'b0001, t == 4);
            if (t >= 3) set_obs(0, 32'hFFFF_FFA5, 4'b0001, (t - 3) == 4);
            step();
        end
        checks++; if (cmp_cnt !== 3'd5) begin errors++; $display("FAIL inorder_cmp: got %0d want 5", cmp_cnt); end
        checks++; if (pkt_cnt !== 3'd1) begin errors++; $display("FAIL inorder_pkt: got %0d want 1", pkt_cnt); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL inorder_errcnt: got %0d want 0", err_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL inorder_idle: got %b want 1", idle); end
    endtask

    task automatic test_mismatch();
        do_clr();
        for (int t = 0; t < 8; t++) begin
            if (t < 5) set_exp(0, 32'h0000_00A5, 4'b0001, t == 4);
            if (t >= 3) set_obs(0, (t == 5) ? 32'h0000_005A : 32'h0000_00A5, 4'b0001, (t - 3) == 4);
            step();
            if (t == 5) begin
                checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL mismatch_pulse: got %b want 1", err[0]); end
            end
            if (t == 6) begin
                checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL mismatch_pulse_end: got %b want 0", err[0]); end
            end
        end
        checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL mismatch_errcnt: got %0d want 1", err_cnt); end
        checks++; if (cmp_cnt !== 3'd5) begin errors++; $display("FAIL mismatch_cmp: got %0d want 5", cmp_cnt); end
    endtask

    task automatic test_keep();
        do_clr();
        set_exp(0, 32'h1122_3344, 4'b0011, 1'b0); step();
        set_obs(0, 32'hAABB_3344, 4'b0011, 1'b0); step();
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL keep_masked: got %0d want 0", err_cnt); end
        set_exp(0, 32'h1122_3344, 4'b0011, 1'b0); step();
        set_obs(0, 32'h1122_3344, 4'b0111, 1'b0); step();
        checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL keep_differs: got %0d want 1", err_cnt); end
        checks++; if (cmp_cnt !== 3'd2) begin errors++; $display("FAIL keep_cmp: got %0d want 2", cmp_cnt); end
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 5; i++) begin
            set_exp(0, 32'(i + 1), 4'b1111, 1'b0);
            step();
            if (i == 3) begin
                checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL ovf_early: got %b want 00", ovf); end
            end
        end
        checks++; if (ovf !== 2'b01) begin errors++; $display("FAIL ovf_set: got %b want 01", ovf); end
        checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL ovf_errcnt: got %0d want 1", err_cnt); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %b want 0", idle); end
        for (int i = 0; i < 4; i++) begin
            set_obs(0, 32'(i + 1), 4'b1111, 1'b0);
            step();
        end
        checks++; if (cmp_cnt !== 3'd4) begin errors++; $display("FAIL ovf_drain_cmp: got %0d want 4", cmp_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ovf_drain_idle: got %b want 1", idle); end
        checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL ovf_drain_errcnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_full_push_pop();
        do_clr();
        for (int i = 0; i < 4; i++) begin
            set_exp(0, 32'(16 + i), 4'b1111, 1'b0);
            step();
        end
        set_exp(0, 32'd20, 4'b1111, 1'b0);
        set_obs(0, 32'd16, 4'b1111, 1'b0);
        step();
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL fullpp_ovf: got %b want 00", ovf); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL fullpp_errcnt: got %0d want 0", err_cnt); end
        for (int i = 0; i < 4; i++) begin
            set_obs(0, 32'(17 + i), 4'b1111, 1'b0);
            step();
        end
        checks++; if (cmp_cnt !== 3'd5) begin errors++; $display("FAIL fullpp_cmp: got %0d want 5", cmp_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fullpp_idle: got %b want 1", idle); end
    endtask

    task automatic test_bypass();
        do_clr();
        set_exp(1, 32'hCAFE_F00D, 4'b1111, 1'b1);
        set_obs(1, 32'hCAFE_F00D, 4'b1111, 1'b1);
        step();
        checks++; if (cmp_cnt !== 3'd1) begin errors++; $display("FAIL bypass_cmp: got %0d want 1", cmp_cnt); end
        checks++; if (unexp !== 2'b00) begin errors++; $display("FAIL bypass_unexp: got %b want 00", unexp); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bypass_idle: got %b want 1", idle); end
        set_obs(1, 32'h1, 4'b1111, 1'b0);
        step();
        checks++; if (unexp !== 2'b10) begin errors++; $display("FAIL unexp_set: got %b want 10", unexp); end
        checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL unexp_errcnt: got %0d want 1", err_cnt); end
        checks++; if (cmp_cnt !== 3'd1) begin errors++; $display("FAIL unexp_cmp: got %0d want 1", cmp_cnt); end
    endtask

    task automatic test_no_handshake();
        do_clr();
        exp_tvalid[0] = 1'b1; exp_tready[0] = 1'b0;
        obs_tvalid[1] = 1'b1; obs_tready[1] = 1'b0;
        step();
        exp_tvalid[1] = 1'b0; exp_tready[1] = 1'b1;
        obs_tvalid[0] = 1'b0; obs_tready[0] = 1'b1;
        step();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL nohs_idle: got %b want 1", idle); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL nohs_errcnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_saturation();
        do_clr();
        for (int i = 0; i < 9; i++) begin
            set_exp(0, 32'h1, 4'b1111, 1'b0);
            set_obs(0, 32'h2, 4'b1111, 1'b0);
            step();
        end
        checks++; if (err_cnt !== 3'd7) begin errors++; $display("FAIL sat_errcnt: got %0d want 7", err_cnt); end
        checks++; if (cmp_cnt !== 3'd7) begin errors++; $display("FAIL sat_cmp: got %0d want 7", cmp_cnt); end
        clr = 1'b1;
        set_exp(0, 32'h3, 4'b1111, 1'b0);
        set_obs(1, 32'h4, 4'b1111, 1'b0);
        step();
        clr = 1'b0;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL clr_idle: got %b want 1", idle); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL clr_errcnt: got %0d want 0", err_cnt); end
        checks++; if (unexp !== 2'b00) begin errors++; $display("FAIL clr_unexp: got %b want 00", unexp); end
        set_exp(0, 32'h1, 4'b1111, 1'b0); set_obs(0, 32'h2, 4'b1111, 1'b0);
        set_exp(1, 32'h3, 4'b1111, 1'b0); set_obs(1, 32'h4, 4'b1111, 1'b0);
        step();
        checks++; if (err_cnt !== 3'd2) begin errors++; $display("FAIL dual_errcnt: got %0d want 2", err_cnt); end
        checks++; if (err !== 2'b11) begin errors++; $display("FAIL dual_err: got %b want 11", err); end
    endtask

    task automatic test_async_reset();
        do_clr();
        set_exp(1, 32'h9, 4'b1111, 1'b1); set_obs(1, 32'h9, 4'b1111, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_exp(0, 32'(40 + i), 4'b1111, 1'b0);
            step();
        end
        set_obs(1, 32'h7, 4'b1111, 1'b0);
        step();
        #6;
        areset = 1'b1;
        #1;
        model_flush();
        checks++; if (cmp_cnt !== 3'd0) begin errors++; $display("FAIL arst_cmp: got %0d want 0", cmp_cnt); end
        checks++; if (pkt_cnt !== 3'd0) begin errors++; $display("FAIL arst_pkt: got %0d want 0", pkt_cnt); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("FAIL arst_errcnt: got %0d want 0", err_cnt); end
        checks++; if (unexp !== 2'b00) begin errors++; $display("FAIL arst_unexp: got %b want 00", unexp); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL arst_idle: got %b want 1", idle); end
        #1;
        areset = 1'b0;
        set_obs(0, 32'd40, 4'b1111, 1'b0);
        step();
        checks++; if (unexp !== 2'b01) begin errors++; $display("FAIL arst_after_unexp: got %b want 01", unexp); end
        checks++; if (cmp_cnt !== 3'd0) begin errors++; $display("FAIL arst_after_cmp: got %0d want 0", cmp_cnt); end
    endtask

    task automatic test_random();
        beat_t hb;
        do_clr();
        for (int t = 0; t < 300; t++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(1, 0) == 1)
                    set_exp(c, $urandom, 4'($urandom), 1'($urandom));
                if ($urandom_range(2, 0) == 0) begin
                    if (mq[c].size() > 0) begin
                        hb = mq[c][0];
                        if ($urandom_range(7, 0) == 0) hb[5] = ~hb[5];
                        set_obs(c, hb[36:5], hb[4:1], hb[0]);
                    end else begin
                        set_obs(c, $urandom, 4'($urandom), 1'($urandom));
                    end
                    if ($urandom_range(5, 0) == 0) obs_tready[c] = 1'b0;
                end
            end
            step();
        end
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (mq[c].size() > 0) begin
                    hb = mq[c][0];
                    set_obs(c, hb[36:5], hb[4:1], hb[0]);
                end
            end
            step();
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL random_drain_idle: got %b want 1", idle); end
    endtask

    initial begin
        areset = 1'b1; clr = 1'b0;
        exp_tvalid = '0; exp_tready = '0; exp_tlast = '0; exp_tdata = '0; exp_tkeep = '0;
        obs_tvalid = '0; obs_tready = '0; obs_tlast = '0; obs_tdata = '0; obs_tkeep = '0;
        model_flush();
        #23;
        test_reset();
        #4;
        areset = 1'b0;
        test_in_order();
        test_mismatch();
        test_keep();
        test_overflow();
        test_full_push_pop();
        test_bypass();
        test_no_handshake();
        test_saturation();
        test_async_reset();
        test_random();
        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
